acdc_capture_controller: RTL and testbench

Mode and capture sequencer for the AC/DC measurement path. Debounces the active-low AC and DC front-panel buttons and holds the selected measurement mode. In an active mode it paces the shared ADC with a fixed sample period, runs the start/done handshake, and writes each conditioned sample into the display line buffer. It signals the VGA side once per completed frame.

---
 rtl/acdc_capture_controller.sv | 192 +++++++++++++++++++
 tb/tb_acdc_capture_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acdc_capture_controller.sv
// AC/DC capture sequencer: debounces the mode buttons, paces the shared ADC,
// conditions each sample and fills the display line buffer one frame at a time.

module acdc_debounce #(
  parameter int CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             fired;

  // fired blocks repeat events until the button is released and rearmed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      fired <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= (cnt == CNT_MAX) && !fired;
      if (btn_n) begin
        cnt   <= '0;
        fired <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_MAX) fired <= 1'b1;
      end
    end
  end

endmodule

module acdc_capture_controller #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int SAMPLE_PERIOD   = 1000,
  parameter int NUM_SAMPLES     = 640,
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ac_button,
  input  logic              dc_button,
  output logic [1:0]        mode,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              frame_done,
  output logic              overrun
);

  localparam int TM_W = $clog2(SAMPLE_PERIOD);
  localparam logic [TM_W-1:0]   TM_LAST   = TM_W'(SAMPLE_PERIOD - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_SAMPLES - 1);

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_AC   = 2'b01;
  localparam logic [1:0] MODE_DC   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_WAIT_DONE,
    S_WRITE
  } state_t;

  state_t            state;
  logic [TM_W-1:0]   timer;
  logic              pend_valid;
  logic [1:0]        pend_mode;
  logic              ac_ev;
  logic              dc_ev;

  logic              new_req;
  logic [1:0]        new_mode;
  logic              req_valid;
  logic [1:0]        req_mode;
  logic              tick;
  logic              apply;
  logic [DATA_W-1:0] cond_data;

  acdc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ac (
    .clk   (clk),
    .rst   (rst),
    .btn_n (ac_button),
    .press (ac_ev)
  );

  acdc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dc (
    .clk   (clk),
    .rst   (rst),
    .btn_n (dc_button),
    .press (dc_ev)
  );

  // Simultaneous AC and DC events cancel each other out.
  always_comb begin
    new_req   = ac_ev ^ dc_ev;
    new_mode  = ac_ev ? MODE_AC : MODE_DC;
    req_valid = new_req | pend_valid;
    req_mode  = new_req ? new_mode : pend_mode;
    tick      = (mode != MODE_NONE) && (timer == TM_LAST);
    apply     = 1'b0;
    case (state)
      S_IDLE, S_WAIT_TICK: apply = req_valid;
      S_WAIT_DONE:         apply = req_valid && adc_done;
      default:             apply = 1'b0;
    endcase
    if (mode == MODE_AC) cond_data = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
    else                 cond_data = adc_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mode       <= MODE_NONE;
      timer      <= '0;
      pend_valid <= 1'b0;
      pend_mode  <= MODE_NONE;
      adc_start  <= 1'b0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      adc_start  <= 1'b0;
      buf_we     <= 1'b0;
      frame_done <= 1'b0;

      if (apply) begin
        timer <= '0;
      end else if (mode != MODE_NONE) begin
        timer <= tick ? '0 : timer + TM_W'(1);
      end

      if (apply) begin
        pend_valid <= 1'b0;
      end else if (new_req) begin
        pend_valid <= 1'b1;
        pend_mode  <= new_mode;
      end

      // Applying a mode drops any in-flight sample and restarts the frame.
      if (apply) begin
        mode     <= req_mode;
        buf_addr <= '0;
        overrun  <= 1'b0;
        state    <= S_WAIT_TICK;
      end else begin
        if (tick && state != S_WAIT_TICK) overrun <= 1'b1;
        case (state)
          S_WAIT_TICK: begin
            if (tick) begin
              state     <= S_START;
              adc_start <= 1'b1;
            end
          end
          S_START: begin
            state <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (adc_done) begin
              state      <= S_WRITE;
              buf_we     <= 1'b1;
              buf_wdata  <= cond_data;
              frame_done <= (buf_addr == ADDR_LAST);
            end
          end
          S_WRITE: begin
            state    <= S_WAIT_TICK;
            buf_addr <= (buf_addr == ADDR_LAST) ? '0 : buf_addr + ADDR_W'(1);
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acdc_capture_controller.sv
// Directed bench for acdc_capture_controller: button debounce, AC/DC frames,
// pending mode requests, overrun and asynchronous reset.

module tb_acdc_capture_controller;

  localparam int DEB = 100;
  localparam int SP  = 8;
  localparam int NS  = 4;
  localparam int AW  = 10;
  localparam int DW  = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ac_button = 1'b1;
  logic          dc_button = 1'b1;
  logic          adc_done = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [1:0]    mode;
  logic          adc_start;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;
  logic          frame_done;
  logic          overrun;

  always #5 clk = ~clk;

  acdc_capture_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .SAMPLE_PERIOD   (SP),
    .NUM_SAMPLES     (NS),
    .ADDR_W          (AW),
    .DATA_W          (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ac_button  (ac_button),
    .dc_button  (dc_button),
    .mode       (mode),
    .adc_start  (adc_start),
    .adc_done   (adc_done),
    .adc_data   (adc_data),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ADC model state
  bit            adc_en;
  int            adc_lat;
  int            adc_cnt;
  logic [DW-1:0] adc_val;
  bit            inject_done;
  int            start_cnt;

  // observed writes and expected write data
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            fd_cyc_q[$];
  logic [AW-1:0] fd_addr_q[$];
  logic [DW-1:0] exp_q[$];

  // One clock: observe this cycle's outputs at the falling edge, then drive the ADC.
  task automatic step_cycle();
    @(negedge clk);
    cyc++;
    if (buf_we) begin
      wr_addr_q.push_back(buf_addr);
      wr_data_q.push_back(buf_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (frame_done) begin
      fd_cyc_q.push_back(cyc);
      fd_addr_q.push_back(buf_addr);
    end
    if (adc_start) start_cnt++;
    adc_done = 1'b0;
    if (adc_cnt > 0) begin
      adc_cnt--;
      if (adc_cnt == 0) begin
        adc_done = 1'b1;
        adc_data = adc_val;
      end
    end
    if (adc_start && adc_en) adc_cnt = adc_lat;
    if (inject_done) begin
      adc_done    = 1'b1;
      adc_data    = adc_val;
      inject_done = 1'b0;
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    fd_cyc_q.delete();
    fd_addr_q.delete();
    exp_q.delete();
    start_cnt = 0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    ac_button   = 1'b1;
    dc_button   = 1'b1;
    adc_done    = 1'b0;
    adc_data    = '0;
    inject_done = 1'b0;
    adc_cnt     = 0;
    adc_en      = 1'b1;
    adc_lat     = 2;
    adc_val     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %0h expected 0", mode); end
    checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL reset_adc_start: got %b expected 0", adc_start); end
    checks++; if (buf_we !== 1'b0) begin errors++; $display("FAIL reset_buf_we: got %b expected 0", buf_we); end
    checks++; if (buf_addr !== '0) begin errors++; $display("FAIL reset_buf_addr: got %0h expected 0", buf_addr); end
    checks++; if (buf_wdata !== '0) begin errors++; $display("FAIL reset_buf_wdata: got %0h expected 0", buf_wdata); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    repeat (20) step_cycle();
    checks++; if (start_cnt !== 0) begin errors++; $display("FAIL idle_no_start: got %0d starts expected 0", start_cnt); end
  endtask

  task automatic test_debounce_short();
    do_reset();
    ac_button = 1'b0;
    repeat (DEB - 1) step_cycle();
    ac_button = 1'b1;
    repeat (10) step_cycle();
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL short_press_mode: got %0h expected 0", mode); end
    checks++; if (start_cnt !== 0) begin errors++; $display("FAIL short_press_start: got %0d starts expected 0", start_cnt); end
  endtask

  task automatic test_ac_frame();
    int k;
    do_reset();
    adc_lat = 2;
    adc_val = 12'h800;
    k = cyc;
    ac_button = 1'b0;
    for (int n = 1; n <= 146; n++) begin
      step_cycle();
      if (n == 100) ac_button = 1'b1;
      if (n == 101) begin
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL ac_mode_early: got %0h expected 0 at edge 101", mode); end
      end
      if (n == 102) begin
        checks++; if (mode !== 2'b01) begin errors++; $display("FAIL ac_mode_apply: got %0h expected 1 at edge 102", mode); end
      end
      if (n == 110) begin
        checks++; if (adc_start !== 1'b1) begin errors++; $display("FAIL ac_first_start: got %b expected 1", adc_start); end
      end
      if (n == 138) begin
        checks++; if (buf_addr !== '0) begin errors++; $display("FAIL ac_addr_wrap: got %0h expected 0", buf_addr); end
        adc_val = 12'h3A5;
      end
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(12'h000);
    exp_q.push_back(12'hBA5);
    checks++; if (wr_addr_q.size() !== 5) begin errors++; $display("FAIL ac_write_count: got %0d expected 5", wr_addr_q.size()); end
    for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
      logic [DW-1:0] exp_d;
      exp_d = exp_q.pop_front();
      checks++; if (wr_addr_q[i] !== AW'(i % NS)) begin errors++; $display("FAIL ac_write_addr[%0d]: got %0h expected %0h", i, wr_addr_q[i], i % NS); end
      checks++; if (wr_data_q[i] !== exp_d) begin errors++; $display("FAIL ac_write_data[%0d]: got %0h expected %0h", i, wr_data_q[i], exp_d); end
      checks++; if (wr_cyc_q[i] - k !== 113 + 8 * i) begin errors++; $display("FAIL ac_write_time[%0d]: got %0d expected %0d", i, wr_cyc_q[i] - k, 113 + 8 * i); end
    end
    checks++; if (fd_cyc_q.size() !== 1) begin errors++; $display("FAIL ac_frame_done_count: got %0d expected 1", fd_cyc_q.size()); end
    if (fd_cyc_q.size() > 0) begin
      checks++; if (fd_cyc_q[0] - k !== 137) begin errors++; $display("FAIL ac_frame_done_time: got %0d expected 137", fd_cyc_q[0] - k); end
      checks++; if (fd_addr_q[0] !== AW'(3)) begin errors++; $display("FAIL ac_frame_done_addr: got %0h expected 3", fd_addr_q[0]); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ac_no_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_dc_pending();
    do_reset();
    adc_en = 1'b0;
    ac_button = 1'b0;
    repeat (DEB) step_cycle();
    ac_button = 1'b1;
    repeat (2) step_cycle();
    checks++; if (mode !== 2'b01) begin errors++; $display("FAIL pend_ac_mode: got %0h expected 1", mode); end
    // ADC never answers: stuck in WAIT_DONE while DC is pressed
    dc_button = 1'b0;
    repeat (DEB) step_cycle();
    dc_button = 1'b1;
    repeat (11) step_cycle();
    checks++; if (mode !== 2'b01) begin errors++; $display("FAIL pend_held_mode: got %0h expected 1", mode); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL pend_overrun_set: got %b expected 1", overrun); end
    adc_val = 12'h555;
    adc_en = 1'b1;
    inject_done = 1'b1;
    step_cycle();
    adc_val = 12'h800;
    for (int m = 1; m <= 12; m++) begin
      step_cycle();
      if (m == 1) begin
        checks++; if (mode !== 2'b10) begin errors++; $display("FAIL pend_dc_mode: got %0h expected 2", mode); end
        checks++; if (buf_we !== 1'b0) begin errors++; $display("FAIL pend_dropped_write: got %b expected 0", buf_we); end
        checks++; if (buf_addr !== '0) begin errors++; $display("FAIL pend_addr: got %0h expected 0", buf_addr); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pend_overrun_clear: got %b expected 0", overrun); end
      end
      if (m == 8) begin
        checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL pend_old_phase_start: got %b expected 0", adc_start); end
      end
      if (m == 9) begin
        checks++; if (adc_start !== 1'b1) begin errors++; $display("FAIL pend_timer_restart: got %b expected 1", adc_start); end
      end
      if (m == 12) begin
        checks++; if (buf_we !== 1'b1) begin errors++; $display("FAIL dc_write_we: got %b expected 1", buf_we); end
        checks++; if (buf_addr !== '0) begin errors++; $display("FAIL dc_write_addr: got %0h expected 0", buf_addr); end
        checks++; if (buf_wdata !== 12'h800) begin errors++; $display("FAIL dc_write_data: got %0h expected 800", buf_wdata); end
      end
    end
    checks++; if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL pend_write_count: got %0d expected 1", wr_addr_q.size()); end
  endtask

  task automatic test_simultaneous();
    int bad_addr;
    int bad_gap;
    int bad_data;
    do_reset();
    adc_lat = 2;
    adc_val = 12'h800;
    dc_button = 1'b0;
    repeat (DEB) step_cycle();
    dc_button = 1'b1;
    repeat (2) step_cycle();
    checks++; if (mode !== 2'b10) begin errors++; $display("FAIL simul_dc_mode: got %0h expected 2", mode); end
    clear_logs();
    ac_button = 1'b0;
    dc_button = 1'b0;
    repeat (DEB) step_cycle();
    ac_button = 1'b1;
    dc_button = 1'b1;
    repeat (30) step_cycle();
    checks++; if (mode !== 2'b10) begin errors++; $display("FAIL simul_mode_kept: got %0h expected 2", mode); end
    bad_addr = 0;
    bad_gap  = 0;
    bad_data = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_data_q[i] !== 12'h800) bad_data++;
      if (i > 0) begin
        if (wr_addr_q[i] !== AW'((wr_addr_q[i-1] + 1) % NS)) bad_addr++;
        if (wr_cyc_q[i] - wr_cyc_q[i-1] != SP) bad_gap++;
      end
    end
    checks++; if (wr_addr_q.size() < 15) begin errors++; $display("FAIL simul_write_count: got %0d expected at least 15", wr_addr_q.size()); end
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL simul_dc_data: got %0d bad writes expected 0", bad_data); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL simul_addr_seq: got %0d breaks expected 0", bad_addr); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL simul_period: got %0d irregular gaps expected 0", bad_gap); end
  endtask

  task automatic test_overrun();
    do_reset();
    adc_lat = 10;
    adc_val = 12'h123;
    ac_button = 1'b0;
    repeat (DEB) step_cycle();
    ac_button = 1'b1;
    for (int n = 101; n <= 150; n++) begin
      step_cycle();
      if (n == 117) begin
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before_tick: got %b expected 0", overrun); end
      end
      if (n == 118) begin
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
      end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    checks++; if (wr_data_q.size() < 1 || wr_data_q[0] !== 12'h923) begin
      errors++; $display("FAIL ovr_ac_data: got %0d writes first %0h expected 923", wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 12'h0);
    end
    adc_lat = 2;
    ac_button = 1'b0;
    repeat (DEB) step_cycle();
    ac_button = 1'b1;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_before_apply: got %b expected 1", overrun); end
    repeat (40) step_cycle();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared: got %b expected 0", overrun); end
    checks++; if (mode !== 2'b01) begin errors++; $display("FAIL ovr_mode: got %0h expected 1", mode); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    adc_en = 1'b0;
    ac_button = 1'b0;
    repeat (DEB) step_cycle();
    ac_button = 1'b1;
    repeat (22) step_cycle();
    checks++; if (mode !== 2'b01) begin errors++; $display("FAIL mid_pre_mode: got %0h expected 1", mode); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL mid_pre_overrun: got %b expected 1", overrun); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL mid_rst_mode: got %0h expected 0", mode); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_overrun: got %b expected 0", overrun); end
    checks++; if (adc_start !== 1'b0 || buf_we !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL mid_rst_strobes: got start=%b we=%b fd=%b expected 0 0 0", adc_start, buf_we, frame_done);
    end
    checks++; if (buf_addr !== '0 || buf_wdata !== '0) begin
      errors++; $display("FAIL mid_rst_buf: got addr=%0h data=%0h expected 0 0", buf_addr, buf_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    adc_en = 1'b1;
    adc_val = 12'hABC;
    inject_done = 1'b1;
    repeat (20) step_cycle();
    checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL mid_stray_write: got %0d writes expected 0", wr_addr_q.size()); end
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL mid_post_mode: got %0h expected 0", mode); end
    checks++; if (start_cnt !== 0) begin errors++; $display("FAIL mid_post_start: got %0d starts expected 0", start_cnt); end
  endtask

  initial begin
    test_reset();
    test_debounce_short();
    test_ac_frame();
    test_dc_pending();
    test_simultaneous();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
